// File: rtl/cond_logic.sv
// -----------------------------------------------------------------------------
// cond_logic
// Purpose: ARM-style conditional-execution unit. Evaluates the instruction
// condition field against the stored architectural flags, qualifies the
// decoder's write requests with the pass/fail result, and maintains the
// {N,Z,C,V} flag register with independent NZ / CV write groups.
//
// Ports:
//   clk       in   1  rising-edge clock
//   reset     in   1  synchronous active-high reset (clears Flags)
//   Cond      in   4  condition field (ARM encoding)
//   ALUFlags  in   4  {N,Z,C,V} produced by the current instruction
//   FlagW     in   2  flag write request: [1] = NZ group, [0] = CV group
//   PCS       in   1  PC write request
//   RegW      in   1  register-file write request
//   MemW      in   1  data-memory write request
//   NoWrite   in   1  compare-class instruction, suppresses register write
//   Stall     in   1  holds the flag register
//   PCSrc     out  1  qualified PC write (combinational)
//   RegWrite  out  1  qualified register write (combinational)
//   MemWrite  out  1  qualified memory write (combinational)
//   CondEx    out  1  condition passed (combinational, stored flags only)
//   Flags     out  4  stored {N,Z,C,V}
// -----------------------------------------------------------------------------
module cond_logic (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       Stall,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    localparam int unsigned FLAG_W = 4;

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;
    logic cond_ex;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Condition decode; deliberately sees only the stored flags.
    always_comb begin
        cond_ex = 1'b1;
        case (Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b1;   // 1111 treated as always-execute
        endcase
    end

    // Next-state for the flag register: each group loads only when its
    // write bit is set, the condition passed and the pipeline is not held.
    always_comb begin
        flags_d = flags_q;
        if (cond_ex && !Stall) begin
            if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    // Flag register; reset wins over any simultaneous write or stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= FLAG_W'(0);
        end else begin
            flags_q <= flags_d;
        end
    end

    // Write qualification is independent of Stall.
    assign CondEx   = cond_ex;
    assign PCSrc    = PCS & cond_ex;
    assign MemWrite = MemW & cond_ex;
    assign RegWrite = RegW & cond_ex & ~NoWrite;
    assign Flags    = flags_q;

endmodule
